// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM states and frame constants.
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int         WORD_BYTES = 4;
  localparam logic [7:0] CHK_INIT   = 8'h00;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Byte-to-word assembler: places each accepted byte into its little-endian
// lane, keeps a running XOR of every data byte, and flags the 4th byte.
module program_loader_byte_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o,
  output logic [7:0]  chk_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  chk_q, chk_d;

  // Next-state: lane insert, byte counter and checksum accumulation.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    chk_d      = chk_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      word_d     = '0;
      chk_d      = CHK_INIT;
    end else if (byte_vld_i) begin
      word_d[{byte_cnt_q, 3'b000} +: 8] = byte_i;
      byte_cnt_d = byte_cnt_q + 2'd1;
      chk_d      = chk_q ^ byte_i;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
      chk_q      <= CHK_INIT;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      chk_q      <= chk_d;
    end
  end

  // word_o includes the byte being accepted this cycle, so the parent can
  // capture the complete word on the same edge that takes the 4th byte.
  assign word_o       = word_d;
  assign word_ready_o = byte_vld_i && !clear_i &&
                        (byte_cnt_q == 2'(WORD_BYTES - 1));
  assign chk_o        = chk_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a byte-serial LEN/DATA/CHK frame, writes each
// assembled word into program memory and releases the CPU only after a
// frame whose checksum matches.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e             state_q, state_d;
  logic [7:0]         n_q, n_d;
  logic [7:0]         idx_q, idx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               xfer;
  logic               asm_clear;
  logic               asm_vld;
  logic               word_ready;
  logic [31:0]        asm_word;
  logic [7:0]         asm_chk;

  assign in_ready = (state_q == S_LEN) || (state_q == S_DATA) ||
                    (state_q == S_CHECK);
  assign xfer     = in_valid && in_ready;
  assign asm_vld  = xfer && (state_q == S_DATA);

  program_loader_byte_assembler u_asm (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (asm_clear),
    .byte_vld_i   (asm_vld),
    .byte_i       (in_data),
    .word_o       (asm_word),
    .word_ready_o (word_ready),
    .chk_o        (asm_chk)
  );

  // Frame FSM next-state; address/data are captured when a word completes
  // so they stay stable through WRITE and hold between writes.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    asm_clear = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          state_d   = S_LEN;
          idx_d     = '0;
          asm_clear = 1'b1;
        end
      end
      S_LEN: begin
        if (xfer) begin
          if (in_data == 8'd0 || int'(in_data) > MAX_WORDS) begin
            state_d = S_ERROR;
          end else begin
            n_d     = in_data;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_ready) begin
          state_d = S_WRITE;
          addr_d  = ADDR_W'({idx_q, 2'b00});
          wdata_d = asm_word;
        end
      end
      S_WRITE: begin
        if (idx_q == n_q - 8'd1) begin
          state_d = S_CHECK;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (in_data == asm_chk) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and write-port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_write      = (state_q == S_WRITE);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERROR);
  assign cpu_hold       = (state_q != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table of directed frames, random
// frames checked against a frame-level model, plus reset/abort sequences.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  len;
    logic [31:0] w0, w1, w2;
    logic [7:0]  chk_flip;
    bit          gaps;
    bit          pulse_mid;
    bit          exp_done;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  wr_t cap[$];

  program_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .cpu_hold       (cpu_hold),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen between edges.
  always @(negedge clk) if (mem_write) cap.push_back({mem_address, mem_write_data});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int w;
    if (gap) begin in_valid = 1'b0; @(negedge clk); end
    in_data = b; in_valid = 1'b1; w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    if (!in_ready) begin
      checks++;
      $display("FAIL in_ready_timeout: got 0 want 1 (byte %0h)", b);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic start_frame();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  function automatic logic [7:0] xor_words(input logic [31:0] words[$]);
    logic [7:0] x = 8'h00;
    foreach (words[i]) x ^= words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    return x;
  endfunction

  // Sends one frame; expected writes come from the frame contents.
  task automatic run_frame(input string tag, input logic [7:0] len, input logic [31:0] words[$],
                           input logic [7:0] chk_b, input bit gaps, input bit pulse_mid,
                           input bit exp_done, input bit exp_err);
    bit ok_len;
    wr_t exp[$];
    logic [31:0] w;
    int nb;
    ok_len = (len != 8'd0) && (len <= 8'd64);
    if (ok_len) foreach (words[i]) exp.push_back({8'(i * 4), words[i]});
    cap.delete();
    start_frame();
    send_byte(len, 1'b0);
    nb = 0;
    if (ok_len) begin
      foreach (words[i]) begin
        w = words[i];
        for (int k = 0; k < 4; k++) begin
          send_byte(w[8*k +: 8], gaps && ($urandom_range(0, 1) == 1));
          nb++;
          if (pulse_mid && nb == 2) begin
            load_start = 1'b1; @(negedge clk); load_start = 1'b0;
          end
        end
      end
      chk({tag, " hold_before_chk"}, {63'd0, cpu_hold}, 64'd1);
      send_byte(chk_b, gaps && ($urandom_range(0, 1) == 1));
    end
    chk({tag, " done"}, {63'd0, done}, {63'd0, exp_done});
    chk({tag, " error"}, {63'd0, error}, {63'd0, exp_err});
    chk({tag, " cpu_hold"}, {63'd0, cpu_hold}, {63'd0, !exp_done});
    chk({tag, " in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, " nwrites"}, 64'(cap.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), 64'(cap[i].addr), 64'(exp[i].addr));
      chk($sformatf("%s data[%0d]", tag, i), 64'(cap[i].data), 64'(exp[i].data));
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    logic [31:0] q[$];
    logic [7:0] len, cb;
    bit good;

    tbl[0] = '{8'd1,  32'h00000013, 0, 0, 8'h00, 0, 0, 1, 0, 1};
    tbl[1] = '{8'd3,  32'h11223344, 32'hAABBCCDD, 32'h01020304, 8'h00, 0, 0, 1, 0, 3};
    tbl[2] = '{8'd3,  32'h11223344, 32'hAABBCCDD, 32'h01020304, 8'h01, 0, 0, 0, 1, 3};
    tbl[3] = '{8'd0,  0, 0, 0, 8'h00, 0, 0, 0, 1, 0};
    tbl[4] = '{8'd65, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0};
    tbl[5] = '{8'd1,  32'hDEADBEEF, 0, 0, 8'h00, 0, 0, 1, 0, 1};
    tbl[6] = '{8'd3,  32'h11223344, 32'hAABBCCDD, 32'h01020304, 8'h00, 1, 1, 1, 0, 3};

    // Reset state.
    #12;
    chk("rst in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst mem_address", 64'(mem_address), 64'd0);
    chk("rst mem_write_data", 64'(mem_write_data), 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst error", {63'd0, error}, 64'd0);
    chk("rst cpu_hold", {63'd0, cpu_hold}, 64'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("idle cpu_hold", {63'd0, cpu_hold}, 64'd1);

    // Directed table.
    for (int t = 0; t < 7; t++) begin
      q = {};
      if (tbl[t].len >= 8'd1 && tbl[t].len <= 8'd64) begin
        q.push_back(tbl[t].w0);
        if (tbl[t].len > 8'd1) q.push_back(tbl[t].w1);
        if (tbl[t].len > 8'd2) q.push_back(tbl[t].w2);
      end
      cb = xor_words(q) ^ tbl[t].chk_flip;
      run_frame($sformatf("vec%0d", t), tbl[t].len, q, cb, tbl[t].gaps, tbl[t].pulse_mid,
                tbl[t].exp_done, tbl[t].exp_err);
      chk($sformatf("vec%0d table_writes", t), 64'(cap.size()), 64'(tbl[t].exp_writes));
    end

    // Reset mid-frame after 2 data bytes.
    cap.delete();
    start_frame();
    send_byte(8'd1, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("midrst in_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst mem_write", {63'd0, mem_write}, 64'd0);
    chk("midrst mem_address", 64'(mem_address), 64'd0);
    chk("midrst mem_write_data", 64'(mem_write_data), 64'd0);
    chk("midrst cpu_hold", {63'd0, cpu_hold}, 64'd1);
    chk("midrst done", {63'd0, done}, 64'd0);
    @(negedge clk); reset = 1'b1;
    chk("midrst nwrites", 64'(cap.size()), 64'd0);
    q = {32'hCAFEF00D, 32'h00000001};
    run_frame("after_rst", 8'd2, q, xor_words(q), 1'b0, 1'b0, 1'b1, 1'b0);

    // Random frames against the frame-level model.
    for (int r = 0; r < 25; r++) begin
      int sel;
      sel = $urandom_range(0, 9);
      q = {};
      if (sel == 0) len = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(65, 255));
      else if (sel == 1) len = 8'd64;
      else len = 8'($urandom_range(1, 4));
      good = (len >= 8'd1 && len <= 8'd64);
      if (good) for (int i = 0; i < int'(len); i++) q.push_back($urandom);
      cb = xor_words(q);
      if ($urandom_range(0, 3) == 0) cb ^= 8'($urandom_range(1, 255));
      run_frame($sformatf("rnd%0d", r), len, q, cb, $urandom_range(0, 1) == 1, 1'b0,
                good && (cb == xor_words(q)), !(good && (cb == xor_words(q))));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side companion to the instruction-fetch path: receives a byte-serial program image and writes it, word by word, into the program memory's write port (write_data/mem_write/address).
- Holds the CPU in reset while loading and releases it only after a frame that passes its checksum.
- Sits between a byte source (host link or testbench) and the program memory; the CPU keeps using the memory's read port.

Parameters:
- ADDR_W, 8, program memory byte-address width (matches the pc_out[7:0] fetch address).
- MAX_WORDS, 64, largest accepted word count; must be ≤ 2^ADDR_W / 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset. The codebase name is kept; the polarity is fixed as active-low.
- load_start  input  1  one-cycle pulse; starts a new load frame.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts in_data this cycle (a byte transfers when in_valid && in_ready).
- mem_address  output  ADDR_W  byte address of the word being written.
- mem_write_data  output  32  assembled instruction word.
- mem_write  output  1  one-cycle write strobe to program memory.
- cpu_hold  output  1  drives the CPU reset; 1 holds the CPU.
- done  output  1  last frame loaded and checksum correct.
- error  output  1  last frame rejected.

Behaviour:
Reset (reset=0, asynchronous):
- State goes to IDLE.
- in_ready=0, mem_write=0, mem_address=0, mem_write_data=0, done=0, error=0.
- cpu_hold=1: the CPU never runs before a good load.

Frame format, in order:
- LEN byte N, valid range 1..MAX_WORDS.
- 4N data bytes, little-endian per word (first byte goes to [7:0]).
- One CHK byte = XOR of all 4N data bytes. The LEN byte is not included.

States:
- IDLE: in_ready=0.
  - load_start -> LEN. Clear done, error, word index, byte count and checksum; cpu_hold=1.
- LEN: in_ready=1. On transfer:
  - N==0 or N>MAX_WORDS -> ERROR.
  - Otherwise latch N -> DATA.
- DATA: in_ready=1. Each transfer shifts the byte into the word buffer at lane byte_cnt and XORs it into the checksum.
  - After the 4th byte -> WRITE.
- WRITE: exactly one cycle, in_ready=0, mem_write=1.
  - mem_address = word_idx*4, truncated to ADDR_W; mem_write_data = assembled word.
  - If word_idx==N-1 -> CHECK; otherwise word_idx++ -> DATA.
- CHECK: in_ready=1. On transfer:
  - byte == checksum -> DONE.
  - Otherwise -> ERROR.
- DONE: done=1, cpu_hold=0, in_ready=0.
  - load_start -> LEN: done=0 and cpu_hold=1 on the next edge.
- ERROR: error=1, cpu_hold=1, in_ready=0.
  - load_start -> LEN.

Boundary and timing rules:
- Bytes presented while in_ready=0 are not consumed; the source must hold them.
- load_start during LEN, DATA, WRITE or CHECK is ignored.
- Every write before an error remains in memory, but the CPU stays held.
- Gaps in in_valid just stall; there is no timeout.
- mem_write is never asserted outside WRITE, and mem_address/mem_write_data hold their values between writes.
- Throughput: 5 cycles per word minimum (4 byte transfers + 1 WRITE).
- Latency: from the CHK transfer edge, done=1 and cpu_hold=0 on the next edge.
- Reset mid-frame: immediate return to IDLE with cpu_hold=1; no partial write strobe is left asserted.

Decomposition:
- Shared package: state encoding (IDLE, LEN, DATA, WRITE, CHECK, DONE, ERROR), WORD_BYTES=4, and the checksum init value 8'h00.
- One natural sub-module, byte_assembler: byte_cnt, lane shift into a 32-bit word, a word_ready pulse, and the running XOR.
- The FSM stays in program_loader.

Test Plan:
- Reset release then load_start; frame 01, 13,00,00,00, CHK 13 -> one mem_write at addr 0x00 with data 0x00000013; done=1; cpu_hold falls one cycle after the CHK transfer.
- N=3 with words 0x11223344, 0xAABBCCDD, 0x01020304 and correct CHK -> writes at 0x00, 0x04, 0x08 with those data values; done=1.
- Same frame with CHK XOR 0x01 -> all three writes occur; error=1, done=0, cpu_hold stays 1.
- LEN=0 and LEN=65 -> ERROR immediately, zero mem_write pulses; then load_start plus a good 1-word frame -> done=1.
- in_valid toggling every other cycle during DATA, plus load_start pulsed mid-frame -> identical writes to the uninterrupted case; the pulse is ignored.
- reset asserted after 2 data bytes -> all outputs go to their reset values asynchronously, no write; after a restart, a full frame loads correctly.
